// File: rtl/clock_divider_multi_pkg.sv
// Shared constants and divisor helpers for the multi-channel clock divider.
// Optional sync alignment is enabled by defining CLOCK_DIVIDER_SYNC_START_EN.
package clock_div_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 32;
  // Helpers operate on a wide word so any WIDTH up to 64 can share them.
  localparam int MAX_WIDTH    = 64;
  localparam logic [MAX_WIDTH-1:0] MIN_DIV = 64'd2;

  function automatic logic [MAX_WIDTH-1:0] eff_div(input logic [MAX_WIDTH-1:0] n);
    logic [MAX_WIDTH-1:0] r;
    if (n < MIN_DIV) begin
      r = MIN_DIV;
    end else begin
      r = n;
    end
    return r;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] high_len(input logic [MAX_WIDTH-1:0] n);
    return n - (n >> 1);
  endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Bus grouping enables, divisors and divided outputs of clock_divider_multi.
// The sync line exists only when CLOCK_DIVIDER_SYNC_START_EN is defined.
interface clock_divider_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
);
  logic [CHANNELS-1:0]       en;
  logic [CHANNELS*WIDTH-1:0] div;
  logic [CHANNELS-1:0]       outclk;
  logic [CHANNELS-1:0]       tick;
`ifdef CLOCK_DIVIDER_SYNC_START_EN
  logic                      sync;

  modport master (output en, output div, output sync, input outclk, input tick);
  modport slave  (input en, input div, input sync, output outclk, output tick);
`else
  modport master (output en, output div, input outclk, input tick);
  modport slave  (input en, input div, output outclk, output tick);
`endif
endinterface

// File: rtl/clock_divider_multi_channel.sv
// One independent divider channel: glitch-free period reload at boundaries.
// A sync input is present only when CLOCK_DIVIDER_SYNC_START_EN is defined.
module clock_div_channel
  import clock_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
`ifdef CLOCK_DIVIDER_SYNC_START_EN
  input  logic             sync,
`endif
  output logic             outclk,
  output logic             tick
);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] act_div_q, act_div_d;
  logic             running_q, running_d;
  logic             outclk_q, outclk_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] eff_s;
  logic [WIDTH-1:0] h_act_s;
  logic [WIDTH-1:0] cnt_inc_s;
  logic             restart_s;

  assign eff_s     = WIDTH'(eff_div(MAX_WIDTH'(div)));
  assign h_act_s   = WIDTH'(high_len(MAX_WIDTH'(act_div_q)));
  assign cnt_inc_s = counter_q + WIDTH'(1);

`ifdef CLOCK_DIVIDER_SYNC_START_EN
  assign restart_s = ~running_q | sync;
`else
  assign restart_s = ~running_q;
`endif

  // Next-state: disable, start/sync, period boundary, or advance within period.
  always_comb begin
    counter_d = counter_q;
    act_div_d = act_div_q;
    running_d = running_q;
    outclk_d  = outclk_q;
    tick_d    = 1'b0;
    if (!en) begin
      counter_d = WIDTH'(0);
      act_div_d = eff_s;
      running_d = 1'b0;
      outclk_d  = 1'b0;
    end else if (restart_s || (counter_q >= act_div_q - WIDTH'(1))) begin
      // Start, sync and boundary all begin a fresh period with the new divisor.
      counter_d = WIDTH'(0);
      act_div_d = eff_s;
      running_d = 1'b1;
      outclk_d  = 1'b1;
      tick_d    = 1'b1;
    end else begin
      counter_d = cnt_inc_s;
      outclk_d  = (cnt_inc_s < h_act_s);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      counter_q <= WIDTH'(0);
      act_div_q <= eff_s;
      running_q <= 1'b0;
      outclk_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      act_div_q <= act_div_d;
      running_q <= running_d;
      outclk_q  <= outclk_d;
      tick_q    <= tick_d;
    end
  end

  assign outclk = outclk_q;
  assign tick   = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: one clock_div_channel per channel.
// Defining CLOCK_DIVIDER_SYNC_START_EN adds a sync input that realigns all enabled channels.
module clock_divider_multi
  import clock_div_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic           refclk,
  input  logic           resetn,
  clock_divider_multi_if.slave bus
);

  logic [CHANNELS-1:0] outclk_s;
  logic [CHANNELS-1:0] tick_s;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clock_div_channel #(.WIDTH(WIDTH)) u_ch (
      .clk    (refclk),
      .resetn (resetn),
      .en     (bus.en[i]),
      .div    (bus.div[i*WIDTH +: WIDTH]),
`ifdef CLOCK_DIVIDER_SYNC_START_EN
      .sync   (bus.sync),
`endif
      .outclk (outclk_s[i]),
      .tick   (tick_s[i])
    );
  end

  assign bus.outclk = outclk_s;
  assign bus.tick   = tick_s;

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Parametrised, multi-channel successor to the single fixed/programmable divider.
- Each channel produces a clock of period N refclk cycles, where N is set per channel at run time.
- Each channel supports odd and even N, runs in a near-50% duty cycle (high phase = ceil(N/2)), and has its own enable.
- Divisor changes take effect only at a period boundary, so the output never glitches. A one-cycle tick strobe marks each rising edge of the output, and display/game timing logic consumes this strobe.

Parameters:
- CHANNELS, 4, number of independent divider channels.
- WIDTH, 32, bit width of each divisor and of each channel counter.

Ports:
- refclk  input  1  reference clock; all logic is on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- en  input  CHANNELS  per-channel run enable.
- div  input  CHANNELS*WIDTH  per-channel divisor N. Channel i uses bits [i*WIDTH +: WIDTH].
- outclk  output  CHANNELS  divided clock outputs, registered.
- tick  output  CHANNELS  one-refclk-cycle pulse, coincident with each outclk rising edge.
- sync  input  1  present only when SYNC_START_EN is defined (see Optional Feature).

Behaviour:
- Reset (resetn=0 at a refclk edge): for every channel, counter=0, outclk=0, tick=0, running=0, and the active divisor register is loaded with the clamped div. Reset applies mid-period with no completion of the current period.
- Clamp: eff(N) = 2 if N<2, otherwise N. H = eff - eff/2 (integer division), so H is the high-phase length.
- Per-channel state: counter[WIDTH], act_div[WIDTH], running flag. No shared FSM; channels are fully independent.
- Disabled (en[i]=0): counter=0, outclk=0, tick=0, running=0, act_div<=eff(div_i). Disabling mid-period forces outclk low on the next edge.
- Start (en[i]=1 and running=0): on the next edge, outclk<=1, tick<=1, counter<=0, running<=1, act_div<=eff(div_i). Latency from en rising to outclk rising is 1 cycle.
- Run (en[i]=1, running=1):
  - If counter >= act_div-1 (boundary): counter<=0, act_div<=eff(div_i), outclk<=1, tick<=1.
  - Else: counter<=counter+1, tick<=0, outclk<=(counter+1 < H_act), where H_act is computed from act_div.
- Resulting waveform: period exactly act_div cycles, high exactly H cycles, low exactly act_div-H cycles.
  - N=2 gives 1/1; N=3 gives 2/1; N=10 gives 5/5.
- A div change mid-period is ignored until the boundary. The current period completes with the old value.
- The ">=" comparison guarantees recovery if act_div is ever below counter+1. Counter arithmetic is WIDTH bits with no overflow, since counter < act_div <= 2^WIDTH-1.
- tick is never asserted while en[i]=0 or during reset.

Optional Feature:
- Macro: CLOCK_DIVIDER_SYNC_START_EN.
- Defined: the sync port exists. When sync=1 at an edge (and resetn=1), every channel with en[i]=1 takes the Start action (counter=0, outclk=1, tick=1, reload act_div), aligning all channel phases. Disabled channels are unaffected. If sync and a boundary coincide, the result is identical to Start.
- Undefined: no sync port and no alignment logic. Channels free-run from their own enable.

Decomposition:
- Shared package clock_div_pkg holds:
  - the default WIDTH/CHANNELS constants;
  - the MIN_DIV=2 constant;
  - a function eff_div(N) for the clamp;
  - a function high_len(N) returning N - N/2.
- One natural sub-module is clock_div_channel: a single channel holding counter, act_div, running, outclk and tick. The top generates CHANNELS instances and slices div.

Test Plan:
- Ch0: div=10, en=1 after reset → outclk rises 1 cycle after en, pattern 5 high / 5 low, tick pulses every 10 cycles, 1 cycle wide.
- Ch1: div=3; ch2: div=0 → ch1 shows 2 high / 1 low, period 3. Ch2 behaves as div=2, period 2, alternating every cycle.
- Ch0 running with div=10; change div to 4 at counter=2 → current period still totals 10 cycles, then 2 high / 2 low repeating, with no short pulse.
- Deassert en at counter=3 of N=8 → outclk=0 next cycle, tick stays 0. Reassert en → outclk high and tick=1 one cycle later.
- resetn=0 for 1 cycle mid-high phase (N=6, counter=1) → all outclk=0 and tick=0 next edge. Outputs restart from the Start action once resetn=1 (en held).
- With CLOCK_DIVIDER_SYNC_START_EN: ch0 div=6 and ch1 div=4 both running out of phase; pulse sync → both outclk=1 and tick=1 on the next edge, rising together again after 12 cycles.
